// File: rtl/rom_reader.sv
// ---------------------------------------------------------------------------
// rom_reader
//
// Read initiator for a small asynchronous-read ROM. A start command sweeps a
// contiguous, wrapping range of ROM addresses; every byte returned by the ROM
// is captured into an output register and streamed downstream on a
// valid/ready handshake. A one-cycle done pulse marks the end of each sweep.
//
// Optional feature (macro ROM_READER_CSUM_EN):
//   Adds a csum output holding the XOR of all bytes captured during the
//   current sweep. Cleared on reset and when a start is accepted; final from
//   the done cycle until the next accepted start.
//
// Parameters:
//   ADDR_W      ROM address width (ROM depth is 2**ADDR_W)
//   DATA_W      ROM data width
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       command strobe, only honoured while idle
//   base_addr   first ROM address of the sweep
//   count       number of words to read (values above the ROM depth clamp)
//   rom_address ROM address, direct copy of the sweep pointer
//   rom_en      ROM enable, high only on cycles that capture a word
//   rom_data    ROM read data, meaningful only while rom_en is high
//   out_data    captured word
//   out_valid   out_data holds a word not yet accepted downstream
//   out_ready   downstream accepts the word on this edge
//   busy        a sweep is in progress (reading or draining)
//   done        one-cycle pulse when a sweep completes
//   csum        XOR of captured bytes (only with ROM_READER_CSUM_EN)
// ---------------------------------------------------------------------------
module rom_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_READER_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    localparam logic [ADDR_W:0] Depth    = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] RemOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] RemZero  = '0;
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    state_e            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_clamped;
    logic              capture;
    logic              transfer;

    // A sweep never reads more than the whole ROM once.
    always_comb begin
        count_clamped = count;
        if (count > Depth) begin
            count_clamped = Depth;
        end
    end

    // The output register may be refilled on the same edge its word leaves,
    // which is what sustains one word per cycle.
    assign capture     = (state == StRead) && (!out_valid || out_ready);
    assign transfer    = out_valid && out_ready;
    assign rom_en      = capture;
    assign rom_address = cur;
    assign busy        = (state == StRead) || (state == StDrain);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur       <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef ROM_READER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;

            // Output register: capture wins over a plain transfer, so a
            // simultaneous capture and transfer keeps out_valid high.
            if (capture) begin
                out_data  <= rom_data;
                out_valid <= 1'b1;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end

`ifdef ROM_READER_CSUM_EN
            if (capture) begin
                csum <= csum ^ rom_data;
            end
`endif

            unique case (state)
                StIdle: begin
                    if (start) begin
                        cur       <= base_addr;
                        remaining <= count_clamped;
`ifdef ROM_READER_CSUM_EN
                        csum      <= '0;
`endif
                        if (count_clamped == RemZero) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StRead;
                        end
                    end
                end

                StRead: begin
                    if (capture) begin
                        cur       <= cur + AddrOne;
                        remaining <= remaining - RemOne;
                        // Last word captured: wait for it to leave.
                        if (remaining == RemOne) begin
                            state <= StDrain;
                        end
                    end
                end

                StDrain: begin
                    if (out_ready) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end

                StDone: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_reader
//
// Self-checking bench for rom_reader. A behavioural ROM answers rom_address;
// expected bytes and addresses are queued when a command is issued and popped
// by a negedge monitor. A table of commands covers the general sweep cases;
// hand-written sequences cover cycle-exact timing, backpressure, empty
// commands, ignored starts and reset mid-sweep. With ROM_READER_CSUM_EN the
// checksum output is checked as well.
// ---------------------------------------------------------------------------
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] count;
    logic [3:0] rom_address;
    logic       rom_en;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef ROM_READER_CSUM_EN
    logic [7:0] csum;
`endif

    rom_reader #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .rom_address(rom_address),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef ROM_READER_CSUM_EN
        ,
        .csum       (csum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    assign rom_data = rom_en ? rom[rom_address] : 8'hxx;

    int n_cmp  = 0;
    int n_fail = 0;
    int xfers  = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [3:0] addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                if (addr_q.size() == 0) flag("extra_rom_read");
                else check("rom_address", 32'(rom_address), 32'(addr_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) flag("extra_word");
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue a command; on return we are in the cycle after the start edge.
    task automatic issue(input logic [3:0] b, input logic [4:0] c);
        int n;
        n = (c > 5'd16) ? 16 : int'(c);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rom[4'(int'(b) + i)]);
            addr_q.push_back(4'(int'(b) + i));
        end
        base_addr = b;
        count     = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  cnt;
        logic [15:0] rdy;
        int          n_exp;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   x0;
        int   d0;
        int   c;
        bit   seen;

        rom[0] = 8'hA9; rom[1] = 8'hFD; rom[2] = 8'hE9; rom[3] = 8'hDC;
        rom[4] = 8'hB9; rom[5] = 8'hC2; rom[6] = 8'hC5; rom[7] = 8'h04;
        for (int i = 8; i < 16; i++) rom[i] = rom[i - 8];

        vecs[0] = '{4'h0, 5'd4,  16'hFFFF, 4,  8'h61};
        vecs[1] = '{4'hE, 5'd4,  16'hFFFF, 4,  8'h95};
        vecs[2] = '{4'h3, 5'd16, 16'hFFFF, 16, 8'h00};
        vecs[3] = '{4'h7, 5'd1,  16'h5A5A, 1,  8'h04};
        vecs[4] = '{4'hA, 5'd20, 16'hFFFF, 16, 8'h00};
        vecs[5] = '{4'h5, 5'd3,  16'hA5C3, 3,  8'h03};

        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_address", 32'(rom_address), 0);
`ifdef ROM_READER_CSUM_EN
        check("rst_csum", 32'(csum), 0);
`endif

        // Test 1: cycle-exact basic sweep.
        x0 = xfers;
        issue(4'h0, 5'd4);
        for (int k = 1; k <= 6; k++) begin
            check("t1_rom_en", 32'(rom_en), 32'(k <= 4));
            check("t1_out_valid", 32'(out_valid), 32'(k >= 2 && k <= 5));
            check("t1_busy", 32'(busy), 32'(k <= 5));
            check("t1_done", 32'(done), 32'(k == 6));
`ifdef ROM_READER_CSUM_EN
            if (k == 6) check("t1_csum", 32'(csum), 32'h61);
`endif
            step();
        end
        check("t1_xfers", 32'(xfers - x0), 4);
        check("t1_idle_busy", 32'(busy), 0);

        // Table-driven sweeps with ready patterns.
        for (int v = 0; v < 6; v++) begin
            x0 = xfers;
            d0 = done_cnt;
            out_ready = vecs[v].rdy[0];
            issue(vecs[v].base, vecs[v].cnt);
            c = 1;
            seen = 1'b0;
            for (int t = 0; t < 300; t++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                out_ready = vecs[v].rdy[c % 16];
                c++;
                step();
            end
            check($sformatf("v%0d_done_seen", v), 32'(seen), 1);
`ifdef ROM_READER_CSUM_EN
            check($sformatf("v%0d_csum", v), 32'(csum), 32'(vecs[v].csum));
`endif
            out_ready = 1'b1;
            step();
            check($sformatf("v%0d_xfers", v), 32'(xfers - x0), 32'(vecs[v].n_exp));
            check($sformatf("v%0d_done_pulses", v), 32'(done_cnt - d0), 1);
            check($sformatf("v%0d_q_left", v), 32'(exp_q.size() + addr_q.size()), 0);
        end

        // Test 3: backpressure.
        x0 = xfers;
        issue(4'h0, 5'd3);
        check("t3_rom_en_first", 32'(rom_en), 1);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_stall_valid", 32'(out_valid), 1);
            check("t3_stall_data", 32'(out_data), 32'hA9);
            check("t3_stall_rom_en", 32'(rom_en), 0);
            step();
        end
        out_ready = 1'b1;
        c = 5;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            c++;
            step();
        end
        check("t3_done_cycle", 32'(seen ? c : 0), 8);
        step();
        check("t3_xfers", 32'(xfers - x0), 3);

        // Test 4a: empty command.
        d0 = done_cnt;
        issue(4'h6, 5'd0);
        check("t4_done", 32'(done), 1);
        check("t4_rom_en", 32'(rom_en), 0);
        check("t4_out_valid", 32'(out_valid), 0);
        check("t4_busy", 32'(busy), 0);
        step();
        check("t4_done_low", 32'(done), 0);
        check("t4_done_pulses", 32'(done_cnt - d0), 1);

        // Test 4b: starts during READ and DONE are ignored.
        x0 = xfers;
        issue(4'h0, 5'd4);
        step();
        base_addr = 4'h8; count = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t4b_done_seen", 32'(seen), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4b_busy_after", 32'(busy), 0);
        check("t4b_rom_en_after", 32'(rom_en), 0);
        check("t4b_xfers", 32'(xfers - x0), 4);
        step();
        check("t4b_still_idle", 32'(busy), 0);

        // Test 5: reset mid-sweep.
        x0 = xfers;
        issue(4'h5, 5'd16);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (xfers - x0 >= 3) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("t5_three_xfers", 32'(seen), 1);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_rom_en", 32'(rom_en), 0);
        for (int k = 0; k < 4; k++) step();
        check("t5_no_done", 32'(done_cnt - d0), 0);
        x0 = xfers;
        issue(4'h0, 5'd1);
        for (int k = 0; k < 4; k++) step();
        check("t5_restart_xfers", 32'(xfers - x0), 1);
        check("t5_q_left", 32'(exp_q.size() + addr_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
